// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation scan controller.
package me_pkg;

    // Reference-pipeline move codes driven on ref_input_Control.
    typedef enum logic [1:0] {
        REF_UP1 = 2'b00,
        REF_UP8 = 2'b01,
        REF_DN1 = 2'b10,
        REF_DN8 = 2'b11
    } ref_ctrl_e;

    typedef enum logic [2:0] {
        StIdle,
        StLoadCurr,
        StRefFill,
        StScan,
        StDone
    } state_e;

    localparam logic CB_PLANES_12 = 1'b1;
    localparam logic CB_PLANES_34 = 1'b0;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/me_scan_ctrl_if.sv
// Control bus between the scan controller and the PE array / SAD accumulator.
interface me_scan_ctrl_if
    import me_pkg::*;
#(
    parameter int unsigned SR_W = 16,
    parameter int unsigned SR_H = 16
);
    localparam int unsigned XW = cnt_w(SR_W);
    localparam int unsigned YW = cnt_w(SR_H);

    logic          start;
    logic          hold;
    logic          busy;
    logic          done;
    logic          in_curr_enable;
    logic          CB_select;
    logic          change_curr;
    logic          change_ref;
    logic [1:0]    ref_input_Control;
    logic [1:0]    abs_Control;
    logic          sad_valid;
    logic [XW-1:0] cand_x;
    logic [YW-1:0] cand_y;
    logic [1:0]    cand_cb;

    modport master (
        input  start, hold,
        output busy, done, in_curr_enable, CB_select, change_curr, change_ref,
               ref_input_Control, abs_Control, sad_valid, cand_x, cand_y, cand_cb
    );

    modport slave (
        output start, hold,
        input  busy, done, in_curr_enable, CB_select, change_curr, change_ref,
               ref_input_Control, abs_Control, sad_valid, cand_x, cand_y, cand_cb
    );

endinterface

// File: rtl/me_snake_addr.sv
// Snake-order candidate walker: even columns run downward, odd columns upward.
module me_snake_addr
    import me_pkg::*;
#(
    parameter int unsigned SR_W = 16,
    parameter int unsigned SR_H = 16,
    localparam int unsigned XW = cnt_w(SR_W),
    localparam int unsigned YW = cnt_w(SR_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output ref_ctrl_e     move,
    output logic          last
);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          up_q;
    logic          col_end;

    assign col_end = up_q ? (y_q == '0) : (y_q == YW'(SR_H - 1));
    assign last    = col_end && (x_q == XW'(SR_W - 1));
    assign x       = x_q;
    assign y       = y_q;

    always_comb begin
        move = REF_UP1;
        if (col_end) begin
            move = REF_DN1;
        end else if (up_q) begin
            move = REF_UP8;
        end else begin
            move = REF_DN8;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x_q  <= '0;
            y_q  <= '0;
            up_q <= 1'b0;
        end else if (step && !last) begin
            if (col_end) begin
                x_q  <= x_q + 1'b1;
                up_q <= ~up_q;
            end else if (up_q) begin
                y_q <= y_q - 1'b1;
            end else begin
                y_q <= y_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/me_scan_ctrl.sv
// Sequencer for the 8-column ME PE array: current-plane preload, reference fill,
// then a snake full search with the four current blocks time-multiplexed per position.
module me_scan_ctrl
    import me_pkg::*;
#(
    parameter int unsigned PE_ROWS = 8,
    parameter int unsigned SR_W    = 16,
    parameter int unsigned SR_H    = 16
) (
    input logic           clk,
    input logic           rst,
    me_scan_ctrl_if.master bus
);

    localparam int unsigned PW = cnt_w(2 * PE_ROWS);
    localparam int unsigned XW = cnt_w(SR_W);
    localparam int unsigned YW = cnt_w(SR_H);

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [1:0]    cb_q, cb_d;

    logic [XW-1:0] snake_x;
    logic [YW-1:0] snake_y;
    ref_ctrl_e     snake_move;
    logic          snake_last;
    logic          snake_step;
    logic          snake_clear;

    assign snake_step  = (state_q == StScan) && (cb_q == 2'd3) && !bus.hold;
    assign snake_clear = (state_q == StIdle) && bus.start && !bus.hold;

    me_snake_addr #(
        .SR_W (SR_W),
        .SR_H (SR_H)
    ) u_snake (
        .clk   (clk),
        .rst   (rst),
        .clear (snake_clear),
        .step  (snake_step),
        .x     (snake_x),
        .y     (snake_y),
        .move  (snake_move),
        .last  (snake_last)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cb_d    = cb_q;
        if (!bus.hold) begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d = StLoadCurr;
                        phase_d = '0;
                    end
                end
                StLoadCurr: begin
                    if (phase_q == PW'(2 * PE_ROWS - 1)) begin
                        state_d = StRefFill;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                StRefFill: begin
                    if (phase_q == PW'(PE_ROWS - 1)) begin
                        state_d = StScan;
                        phase_d = '0;
                        cb_d    = 2'd0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                StScan: begin
                    cb_d = cb_q + 1'b1;
                    if (cb_q == 2'd3 && snake_last) begin
                        state_d = StDone;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            phase_q <= '0;
            cb_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cb_q    <= cb_d;
        end
    end

    // Outputs decode the registers; hold only masks the strobes, so tags stay put.
    always_comb begin
        bus.busy              = (state_q != StIdle);
        bus.done              = 1'b0;
        bus.in_curr_enable    = 1'b0;
        bus.CB_select         = CB_PLANES_34;
        bus.change_curr       = 1'b0;
        bus.change_ref        = 1'b0;
        bus.ref_input_Control = REF_UP1;
        bus.abs_Control       = 2'd0;
        bus.sad_valid         = 1'b0;
        bus.cand_x            = '0;
        bus.cand_y            = '0;
        bus.cand_cb           = 2'd0;
        case (state_q)
            StLoadCurr: begin
                bus.in_curr_enable = !bus.hold;
                bus.CB_select      = (phase_q < PW'(PE_ROWS)) ? CB_PLANES_12 : CB_PLANES_34;
                bus.change_curr    = !bus.hold && (phase_q == PW'(2 * PE_ROWS - 1));
            end
            StRefFill: begin
                bus.change_ref        = !bus.hold;
                bus.ref_input_Control = REF_DN8;
            end
            StScan: begin
                bus.sad_valid   = !bus.hold;
                bus.abs_Control = cb_q;
                bus.cand_cb     = cb_q;
                bus.cand_x      = snake_x;
                bus.cand_y      = snake_y;
                if (cb_q == 2'd3 && !snake_last) begin
                    bus.change_ref        = !bus.hold;
                    bus.ref_input_Control = snake_move;
                end
            end
            StDone:  bus.done = !bus.hold;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_me_scan_ctrl.sv
// Scoreboard bench: a 2x3 search instance and a degenerate 1x1 instance.
module tb_me_scan_ctrl;
    import me_pkg::*;

    localparam int P = 8;

    typedef struct {
        logic [31:0] busy, done, ice, cbs, chc, chr, ric, absc, sv, cx, cy, ccb;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    me_scan_ctrl_if #(.SR_W(2), .SR_H(3)) bus0();
    me_scan_ctrl_if #(.SR_W(1), .SR_H(1)) bus1();

    me_scan_ctrl #(.PE_ROWS(P), .SR_W(2), .SR_H(3)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    me_scan_ctrl #(.PE_ROWS(P), .SR_W(1), .SR_H(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    rec_t q0[$];
    rec_t q1[$];
    rec_t obs0, obs1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always_comb begin
        obs0      = '{default: '0};
        obs0.busy = 32'(bus0.busy);
        obs0.done = 32'(bus0.done);
        obs0.ice  = 32'(bus0.in_curr_enable);
        obs0.cbs  = 32'(bus0.CB_select);
        obs0.chc  = 32'(bus0.change_curr);
        obs0.chr  = 32'(bus0.change_ref);
        obs0.ric  = 32'(bus0.ref_input_Control);
        obs0.absc = 32'(bus0.abs_Control);
        obs0.sv   = 32'(bus0.sad_valid);
        obs0.cx   = 32'(bus0.cand_x);
        obs0.cy   = 32'(bus0.cand_y);
        obs0.ccb  = 32'(bus0.cand_cb);
    end

    always_comb begin
        obs1      = '{default: '0};
        obs1.busy = 32'(bus1.busy);
        obs1.done = 32'(bus1.done);
        obs1.ice  = 32'(bus1.in_curr_enable);
        obs1.cbs  = 32'(bus1.CB_select);
        obs1.chc  = 32'(bus1.change_curr);
        obs1.chr  = 32'(bus1.change_ref);
        obs1.ric  = 32'(bus1.ref_input_Control);
        obs1.absc = 32'(bus1.abs_Control);
        obs1.sv   = 32'(bus1.sad_valid);
        obs1.cx   = 32'(bus1.cand_x);
        obs1.cy   = 32'(bus1.cand_y);
        obs1.ccb  = 32'(bus1.cand_cb);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs at the t-th advancing cycle after start, derived from indices.
    function automatic rec_t model(input int t, input int sw, input int sh, input bit held);
        rec_t e;
        int   last_t, s, cand, cb, col, r;
        e      = '{default: '0};
        last_t = 3 * P + 4 * sw * sh + 1;
        if (t < 1 || t > last_t) return e;
        e.busy = 1;
        if (t <= 2 * P) begin
            e.ice = 32'(!held);
            e.cbs = 32'(t <= P);
            e.chc = 32'((t == 2 * P) && !held);
        end else if (t <= 3 * P) begin
            e.chr = 32'(!held);
            e.ric = 3;
        end else if (t < last_t) begin
            s      = t - 3 * P - 1;
            cand   = s / 4;
            cb     = s % 4;
            col    = cand / sh;
            r      = cand % sh;
            e.sv   = 32'(!held);
            e.absc = 32'(cb);
            e.ccb  = 32'(cb);
            e.cx   = 32'(col);
            e.cy   = 32'((col % 2 == 0) ? r : sh - 1 - r);
            if (cb == 3 && cand != sw * sh - 1) begin
                e.chr = 32'(!held);
                e.ric = (r == sh - 1) ? 2 : ((col % 2 == 0) ? 3 : 1);
            end
        end else begin
            e.done = 32'(!held);
        end
        return e;
    endfunction

    task automatic push_run(input int which, input int sw, input int sh,
                            input int hold_t, input int hold_n);
        int total;
        total = 3 * P + 4 * sw * sh + 1;
        for (int t = 1; t <= total; t++) begin
            if (t == hold_t) begin
                for (int k = 0; k < hold_n; k++) begin
                    if (which == 0) q0.push_back(model(t, sw, sh, 1'b1));
                    else            q1.push_back(model(t, sw, sh, 1'b1));
                end
            end
            if (which == 0) q0.push_back(model(t, sw, sh, 1'b0));
            else            q1.push_back(model(t, sw, sh, 1'b0));
        end
    endtask

    task automatic cmp(input string who, input rec_t g, input rec_t e);
        check({who, ".busy"}, g.busy, e.busy);
        check({who, ".done"}, g.done, e.done);
        check({who, ".in_curr_enable"}, g.ice, e.ice);
        check({who, ".CB_select"}, g.cbs, e.cbs);
        check({who, ".change_curr"}, g.chc, e.chc);
        check({who, ".change_ref"}, g.chr, e.chr);
        check({who, ".ref_input_Control"}, g.ric, e.ric);
        check({who, ".abs_Control"}, g.absc, e.absc);
        check({who, ".sad_valid"}, g.sv, e.sv);
        check({who, ".cand_x"}, g.cx, e.cx);
        check({who, ".cand_y"}, g.cy, e.cy);
        check({who, ".cand_cb"}, g.ccb, e.ccb);
    endtask

    // Drive one cycle's inputs, then compare that cycle's outputs with the scoreboard.
    task automatic step(input bit s0, input bit h, input bit r, input bit s1);
        rec_t e;
        @(posedge clk);
        #1;
        bus0.start = s0;
        bus0.hold  = h;
        bus1.start = s1;
        bus1.hold  = h;
        rst        = r;
        #1;
        e = '{default: '0};
        if (q0.size() > 0) e = q0.pop_front();
        cmp("dut0", obs0, e);
        e = '{default: '0};
        if (q1.size() > 0) e = q1.pop_front();
        cmp("dut1", obs1, e);
        if (r) begin
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic run_case(input bit s1, input int hold_at, input int rst_at,
                            input int ign_a, input int ign_b, input int ncyc);
        step(1'b1, 1'b0, 1'b0, s1);
        push_run(0, 2, 3, hold_at, 3);
        if (s1) push_run(1, 1, 1, 0, 0);
        for (int c = 1; c <= ncyc; c++) begin
            step((c == ign_a) || (c == ign_b),
                 (hold_at > 0) && (c >= hold_at) && (c < hold_at + 3),
                 (c == rst_at), 1'b0);
        end
    endtask

    initial begin
        bus0.start = 1'b0;
        bus0.hold  = 1'b0;
        bus1.start = 1'b0;
        bus1.hold  = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Nominal 2x3 alongside degenerate 1x1; ends on the done cycle.
        run_case(1'b1, 0, 0, 0, 0, 49);
        // Back-to-back start in the IDLE cycle after done, with a 3-cycle hold.
        run_case(1'b0, 31, 0, 0, 0, 55);
        // Starts during LOAD_CURR and SCAN must be ignored.
        run_case(1'b0, 0, 0, 5, 30, 52);
        // Mid-scan reset, then a clean run.
        run_case(1'b0, 0, 30, 0, 0, 33);
        run_case(1'b0, 0, 0, 0, 0, 52);

        check("q0_drained", 32'(q0.size()), 0);
        check("q1_drained", 32'(q1.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/me_scan_ctrl.md
# me_scan_ctrl

Sequencing controller for the 8-column motion-estimation PE array built from dual-pixel current/reference PEs. It drives the shared control bus of the array. First it preloads four current-block pixel planes, then fills the reference pipeline. It then walks a snake-order full search over a SR_W × SR_H candidate window, time-multiplexing the four current blocks onto each reference position. It emits a per-cycle candidate tag so the downstream SAD accumulator knows which block and position each abs_out slice belongs to.

## Interface
- PE_ROWS, 8: array depth; cycles per current-plane load and per reference fill.
- SR_W, 16: candidate columns (≥1).
- SR_H, 16: candidate rows (≥1).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- hold  in  1  freeze: counters and state hold, all strobes forced low.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last candidate.
- in_curr_enable  out  1  current-pixel shift strobe to the PEs.
- CB_select  out  1  1 = load/forward planes 1&2, 0 = planes 3&4.
- change_curr  out  1  one-cycle pulse at the end of current load.
- change_ref  out  1  reference shift strobe.
- ref_input_Control  out  2  00 up_adj1, 01 up_adj8, 10 down_adj1, 11 down_adj8.
- abs_Control  out  2  current block compared this cycle (0..3).
- sad_valid  out  1  abs_out of the array is meaningful this cycle.
- cand_x  out  $clog2(SR_W) (min 1)  candidate column of the current abs_out.
- cand_y  out  $clog2(SR_H) (min 1)  candidate row of the current abs_out.
- cand_cb  out  2  equals abs_Control when sad_valid is high.

## Operation
- States: IDLE → LOAD_CURR → REF_FILL → SCAN → DONE → IDLE.
- IDLE: all strobes low. start=1 moves to LOAD_CURR on the next cycle. start in any other state is ignored.
- LOAD_CURR: 2·PE_ROWS cycles with in_curr_enable=1.
  - The first PE_ROWS cycles have CB_select=1; the last PE_ROWS cycles have CB_select=0.
  - change_curr=1 on the final LOAD_CURR cycle only.
- REF_FILL: PE_ROWS cycles with change_ref=1 and ref_input_Control=11.
- SCAN: 4 cycles per candidate. abs_Control steps 0,1,2,3; sad_valid=1; cand_cb=abs_Control.
  - change_ref=1 only on the abs_Control=3 cycle, and never on the last candidate.
- Snake order: even columns run y 0→SR_H-1, odd columns run y SR_H-1→0.
  - Move down within a column: ref_input_Control=11.
  - Move up within a column: ref_input_Control=01.
  - Column step (at the end of a column): ref_input_Control=10, x+1, y unchanged.
- DONE: done=1 for one cycle, busy still 1, then IDLE.
- hold=1:
  - The state and all counters keep their values.
  - in_curr_enable, change_ref, change_curr and sad_valid are 0.
  - abs_Control, cand_* and CB_select keep their values.
  - Operation resumes exactly where it stopped.
- rst=1 (including mid-operation): return to IDLE next edge; no done.
- Reset values: every output 0, including ref_input_Control=00 and CB_select=0.
- SR_W=1: no column step. SR_H=1: every move is a column step (10).

## Timing
- All outputs are registered and decoded from state/counter registers. abs_Control/cand_* align with sad_valid in the same cycle, so the tag latency is 0 relative to abs_out.
- With start high at edge 0 and no hold:
  - LOAD_CURR occupies cycles 1..2·PE_ROWS.
  - REF_FILL occupies the next PE_ROWS cycles.
  - SCAN occupies 4·SR_W·SR_H cycles.
  - done follows immediately.
- Total busy cycles without hold: 3·PE_ROWS + 4·SR_W·SR_H + 1.
- Every hold cycle extends this by one.
- back-to-back: start may be asserted in the cycle after done (IDLE); the controller accepts it.

## Structure
- Shared package me_pkg:
  - ref_input_Control encodings (REF_UP1, REF_UP8, REF_DN1, REF_DN8).
  - State enum.
  - The CB_select plane constants.
- Sub-module me_snake_addr: x/y counters, direction bit, and move-code generation. It takes a step input and gives x, y, move code and last outputs.
- The FSM and phase counter stay in the top.

## Test plan
- Reset/idle: rst held 3 cycles, then idle 5 cycles → all outputs 0, busy=0.
- Nominal, PE_ROWS=8, SR_W=2, SR_H=3, start at edge 0:
  - in_curr_enable in cycles 1–16, with CB_select=1 in 1–8 and 0 in 9–16; change_curr in cycle 16.
  - change_ref/11 in cycles 17–24.
  - SCAN 25–48 with (x,y) sequence (0,0),(0,1),(0,2),(1,2),(1,1),(1,0); ref moves 11,11,10,01,01.
  - done in cycle 49.
- Hold: hold=1 for 3 cycles at SCAN cycle (0,1),cb=2 → tags frozen, strobes 0; resume at cb=2; done in cycle 52.
- Mid-scan reset: rst at cycle 30 → busy=0 next cycle, no done; a new start completes normally.
- Ignored start: start pulses in LOAD_CURR and SCAN → timing identical to the nominal case.
- Degenerate SR_W=1, SR_H=1: SCAN 4 cycles, change_ref never asserted in SCAN, done at 3·PE_ROWS+5.
